// File: rtl/cordic_vectoring.sv
// ---------------------------------------------------------------------------
// cordic_vectoring
//
// Iterative CORDIC engine in vectoring mode. It converts a signed 13-bit
// (I, Q) sample pair into a phase (PM) and a magnitude (AM). The engine
// performs one micro-rotation per clock. A small state machine and an
// iteration counter sequence the work.
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   defined   : an extra GAIN state scales X by ~0.607178. AM then
//               approximates |(I,Q)|. Latency is ITER+1 cycles.
//   undefined : AM is the raw CORDIC X, about 1.6468*|(I,Q)|, saturated.
//               Latency is ITER cycles.
//
// Parameters
//   ITER          number of micro-rotations, legal range 1..15
//
// Ports
//   CLK1          system clock, rising edge
//   RST           synchronous active-high reset
//   Cordic_Enable start strobe, sampled in IDLE and DONE
//   I, Q          signed two's complement input sample
//   PM            signed phase, pi/4096 per LSB
//   AM            unsigned saturating magnitude
//   Cordic_Ready  result-valid level, high while in DONE
// ---------------------------------------------------------------------------
module cordic_vectoring #(
  parameter int ITER = 12
) (
  input  logic        CLK1,
  input  logic        RST,
  input  logic        Cordic_Enable,
  input  logic [12:0] I,
  input  logic [12:0] Q,
  output logic [12:0] PM,
  output logic [12:0] AM,
  output logic        Cordic_Ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [1:0] S_GAIN = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] K_LAST = 4'(ITER - 1);

  logic [1:0]         state;
  logic [3:0]         k;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic signed [16:0] z;

  logic signed [15:0] i_ext;
  logic signed [15:0] q_ext;
  logic signed [15:0] x_pre;
  logic signed [15:0] y_pre;
  logic signed [16:0] z_pre;

  logic signed [15:0] x_shift;
  logic signed [15:0] y_shift;
  logic signed [16:0] atan_k;
  logic signed [15:0] x_next;
  logic signed [15:0] y_next;
  logic signed [16:0] z_next;

  // Arctangent table. Z uses 2^15 = pi, so entry k is
  // round(atan(2^-k) * 2^15 / pi).
  function automatic logic signed [16:0] atan_lut(input logic [3:0] idx);
    logic signed [16:0] v;
    case (idx)
      4'd0:    v = 17'sd8192;
      4'd1:    v = 17'sd4836;
      4'd2:    v = 17'sd2555;
      4'd3:    v = 17'sd1297;
      4'd4:    v = 17'sd651;
      4'd5:    v = 17'sd326;
      4'd6:    v = 17'sd163;
      4'd7:    v = 17'sd81;
      4'd8:    v = 17'sd41;
      4'd9:    v = 17'sd20;
      4'd10:   v = 17'sd10;
      4'd11:   v = 17'sd5;
      4'd12:   v = 17'sd3;
      4'd13:   v = 17'sd1;
      4'd14:   v = 17'sd1;
      default: v = 17'sd0;
    endcase
    return v;
  endfunction

  // Z carries 3 fractional bits beyond the PM scale. A result of exactly +pi
  // truncates to -4096, which is the same angle.
  function automatic logic [12:0] phase_of(input logic signed [16:0] zv);
    return 13'((zv + 17'sd4) >>> 3);
  endfunction

  // Clamp to the unsigned 13-bit output range.
  function automatic logic [12:0] sat_mag(input logic signed [29:0] v);
    logic [12:0] r;
    if (v < 30'sd0) begin
      r = 13'd0;
    end else if (v > 30'sd8191) begin
      r = 13'd8191;
    end else begin
      r = 13'(v);
    end
    return r;
  endfunction

  assign i_ext = 16'(signed'(I));
  assign q_ext = 16'(signed'(Q));

  // Rotate left-half-plane inputs by pi so the iterations always start with
  // X >= 0. The sign of Q chooses +pi or -pi, which keeps the final phase
  // inside the output range. The 16-bit width lets I = -4096 negate exactly.
  always_comb begin
    x_pre = i_ext;
    y_pre = q_ext;
    z_pre = 17'sd0;
    if (I[12]) begin
      x_pre = -i_ext;
      y_pre = -q_ext;
      z_pre = Q[12] ? -17'sd32768 : 17'sd32768;
    end
  end

  // One micro-rotation. The step rotates toward Y = 0, and the angle moved
  // is accumulated in Z.
  always_comb begin
    x_shift = x >>> k;
    y_shift = y >>> k;
    atan_k  = atan_lut(k);
    if (y[15]) begin
      x_next = x - y_shift;
      y_next = y + x_shift;
      z_next = z - atan_k;
    end else begin
      x_next = x + y_shift;
      y_next = y - x_shift;
      z_next = z + atan_k;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [29:0] x_wide;
  logic signed [29:0] gain_acc;
  logic [12:0]        am_gain;

  // X * 2487 / 4096 (~0.607178) as shift-adds:
  // X/2 + X/8 - X/64 - X/512 - X/4096.
  // A single round-half-up happens before the final shift.
  always_comb begin
    x_wide   = 30'(x);
    gain_acc = (x_wide <<< 11) + (x_wide <<< 9) - (x_wide <<< 6)
             - (x_wide <<< 3) - x_wide + 30'sd2048;
    am_gain  = sat_mag(gain_acc >>> 12);
  end
`endif

  // Sequencer and datapath registers. In the uncompensated build the
  // outputs are written on the same edge as the last micro-rotation,
  // from that rotation's combinational result.
  always_ff @(posedge CLK1) begin
    if (RST) begin
      state <= S_IDLE;
      k     <= 4'd0;
      x     <= 16'sd0;
      y     <= 16'sd0;
      z     <= 17'sd0;
      PM    <= 13'd0;
      AM    <= 13'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Cordic_Enable) begin
            x     <= x_pre;
            y     <= y_pre;
            z     <= z_pre;
            k     <= 4'd0;
            state <= S_ROT;
          end
        end
        S_ROT: begin
          x <= x_next;
          y <= y_next;
          z <= z_next;
          k <= k + 4'd1;
          if (k == K_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= S_GAIN;
`else
            PM    <= phase_of(z_next);
            AM    <= sat_mag(30'(x_next));
            state <= S_DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          PM    <= phase_of(z);
          AM    <= am_gain;
          state <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // The upstream FSM polls this level. It drops on the edge that restarts.
  assign Cordic_Ready = (state == S_DONE);

endmodule
